// File: rtl/beamformer_pkg.sv
// Shared state encoding and width helpers for the delay-and-sum slice engine.
package beamformer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Sum of n signed sw-bit slices never overflows sw + clog2(n) bits.
  function automatic int sum_width(input int sw, input int nch);
    return sw + $clog2(nch);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_table.sv
// Per-channel delay registers with a single write port and a combinational read mux.
module delay_table
  import beamformer_pkg::*;
#(
  parameter int NCH = 3,
  parameter int DW  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [idx_width(NCH)-1:0] wr_ch,
  input  logic [DW-1:0]             wr_val,
  input  logic [idx_width(NCH)-1:0] rd_ch,
  output logic [DW-1:0]             rd_val
);
  localparam int CW = idx_width(NCH);

  logic [DW-1:0] tbl_q [NCH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) tbl_q[c] <= '0;
    end else if (wr_en) begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_ch == CW'(c)) tbl_q[c] <= wr_val;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NCH; c++) begin
      if (rd_ch == CW'(c)) rd_val = tbl_q[c];
    end
  end

endmodule

// File: rtl/slice_delay_sum.sv
// Delay-and-sum over NCH packed slices: one read per channel per sample, then one
// output write. Each sample takes NCH+2 cycles (NCH+1 RUN slots plus WRITE).
module slice_delay_sum
  import beamformer_pkg::*;
#(
  parameter int NCH = 3,
  parameter int SW  = 32,
  parameter int AW  = 11,
  parameter int OAW = 10,
  parameter int DW  = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [AW-1:0]                num_samples,
  input  logic                         dly_wr_en,
  input  logic [idx_width(NCH)-1:0]    dly_wr_ch,
  input  logic [DW-1:0]                dly_wr_val,
  output logic [AW-1:0]                ram_addr,
  output logic                         ram_rden,
  input  logic [NCH*SW-1:0]            ram_q,
  output logic [OAW-1:0]               out_addr,
  output logic [sum_width(SW,NCH)-1:0] out_data,
  output logic                         out_wren,
  output logic                         busy,
  output logic                         done
);
  localparam int CW = idx_width(NCH);
  localparam int OW = sum_width(SW, NCH);
  localparam int TW = idx_width(NCH + 1);
  localparam int XW = AW + DW;

  state_t               state_q, state_d;
  logic [AW-1:0]        num_q, num_d;
  logic [AW-1:0]        n_q, n_d;
  logic [TW-1:0]        slot_q, slot_d;
  logic signed [OW-1:0] acc_q, acc_d;
  logic                 rvalid_q, rvalid_d;

  logic [DW-1:0] rd_dly;
  logic [XW-1:0] n_ext, d_ext;
  logic [SW-1:0] slice;
  logic          issue, last;

  delay_table #(.NCH(NCH), .DW(DW)) u_delay_table (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (dly_wr_en && (state_q == S_IDLE)),
    .wr_ch  (dly_wr_ch),
    .wr_val (dly_wr_val),
    .rd_ch  (CW'(slot_q)),
    .rd_val (rd_dly)
  );

  assign n_ext = XW'(n_q);
  assign d_ext = XW'(rd_dly);
  assign issue = (state_q == S_RUN) && (slot_q < TW'(NCH));
  assign last  = ((AW+1)'(n_q) + (AW+1)'(1)) == (AW+1)'(num_q);

  // Data returned in slot s belongs to the channel read in slot s-1.
  always_comb begin
    slice = '0;
    for (int c = 0; c < NCH; c++) begin
      if (slot_q == TW'(c + 1)) slice = ram_q[c*SW +: SW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      n_q      <= '0;
      slot_q   <= '0;
      acc_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      n_q      <= n_d;
      slot_q   <= slot_d;
      acc_q    <= acc_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    n_d      = n_q;
    slot_d   = slot_q;
    acc_d    = acc_q;
    ram_addr = '0;
    ram_rden = 1'b0;
    out_addr = '0;
    out_data = '0;
    out_wren = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    // Taps reaching before sample 0 read nothing and contribute zero.
    if (issue && (n_ext >= d_ext)) begin
      ram_rden = 1'b1;
      ram_addr = AW'(n_ext - d_ext);
    end
    rvalid_d = ram_rden;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d   = num_samples;
          n_d     = '0;
          slot_d  = '0;
          state_d = (num_samples == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (slot_q == '0)  acc_d = '0;
        else if (rvalid_q) acc_d = acc_q + OW'(signed'(slice));
        if (slot_q == TW'(NCH)) begin
          slot_d  = '0;
          state_d = S_WRITE;
        end else begin
          slot_d = slot_q + TW'(1);
        end
      end
      S_WRITE: begin
        busy     = 1'b1;
        out_wren = 1'b1;
        out_addr = OAW'(n_q);
        out_data = acc_q;
        if (last) begin
          state_d = S_DONE;
        end else begin
          n_d     = n_q + AW'(1);
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && ((state_q == S_RUN) || (state_q == S_WRITE))) begin
      out_wren = 1'b0;
      slot_d   = '0;
      state_d  = S_IDLE;
    end
  end

endmodule

// File: tb/tb_slice_delay_sum.sv
// Directed bench for slice_delay_sum: two instances (default and OAW=2) share one RAM model.
module tb_slice_delay_sum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [10:0] num_samples = '0;
  logic        dly_wr_en = 1'b0;
  logic [1:0]  dly_wr_ch = '0;
  logic [5:0]  dly_wr_val = '0;
  logic [10:0] ram_addr;
  logic        ram_rden;
  logic [95:0] ram_q = '0;
  logic [9:0]  out_addr;
  logic [33:0] out_data;
  logic        out_wren, busy, done;

  logic [10:0] d2_ram_addr;
  logic        d2_ram_rden;
  logic [1:0]  d2_out_addr;
  logic [33:0] d2_out_data;
  logic        d2_out_wren, d2_busy, d2_done;

  int errors = 0;
  int checks = 0;
  int mode = 0;
  int rden_cnt, wren_cnt, busy_cnt, done_cnt;
  logic [9:0]  wa  [$];
  logic [33:0] wd  [$];
  logic [1:0]  wa2 [$];

  slice_delay_sum dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_samples(num_samples),
    .dly_wr_en(dly_wr_en), .dly_wr_ch(dly_wr_ch), .dly_wr_val(dly_wr_val),
    .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_q(ram_q),
    .out_addr(out_addr), .out_data(out_data), .out_wren(out_wren),
    .busy(busy), .done(done)
  );

  slice_delay_sum #(.OAW(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_samples(num_samples),
    .dly_wr_en(dly_wr_en), .dly_wr_ch(dly_wr_ch), .dly_wr_val(dly_wr_val),
    .ram_addr(d2_ram_addr), .ram_rden(d2_ram_rden), .ram_q(ram_q),
    .out_addr(d2_out_addr), .out_data(d2_out_data), .out_wren(d2_out_wren),
    .busy(d2_busy), .done(d2_done)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] mk_word(input logic [10:0] a);
    logic [31:0] s;
    case (mode)
      0:       s = {21'd0, a};
      1:       s = 32'd1;
      default: s = 32'h8000_0000;
    endcase
    return {s, s, s};
  endfunction

  always @(posedge clk) if (ram_rden) ram_q <= mk_word(ram_addr);

  always @(negedge clk) begin
    #2;
    if (ram_rden) rden_cnt++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (out_wren) begin
      wren_cnt++;
      wa.push_back(out_addr);
      wd.push_back(out_data);
    end
    if (d2_out_wren) wa2.push_back(d2_out_addr);
  end

  task automatic clear_mon();
    rden_cnt = 0; wren_cnt = 0; busy_cnt = 0; done_cnt = 0;
    wa.delete(); wd.delete(); wa2.delete();
  endtask

  task automatic set_dly(input logic [1:0] ch, input logic [5:0] val);
    @(negedge clk);
    dly_wr_en = 1'b1; dly_wr_ch = ch; dly_wr_val = val;
    @(negedge clk);
    dly_wr_en = 1'b0;
  endtask

  // cyc = negedges from the start edge until done is seen, -1 on timeout
  task automatic do_run(input logic [10:0] ns, input bit disturb, input bit wr_same,
                        output int cyc);
    @(negedge clk);
    clear_mon();
    num_samples = ns;
    start = 1'b1;
    if (wr_same) begin dly_wr_en = 1'b1; dly_wr_ch = 2'd0; dly_wr_val = 6'd1; end
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      start = 1'b0;
      dly_wr_en = 1'b0;
      if (disturb && i == 3) begin
        start = 1'b1; dly_wr_en = 1'b1; dly_wr_ch = 2'd1; dly_wr_val = 6'd5; num_samples = 11'd1;
      end
      if (done) begin cyc = i; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, ram_rden, out_wren} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, ram_rden, out_wren});
    end
    checks++;
    if ({ram_addr, out_addr, out_data} !== '0) begin
      errors++; $display("FAIL reset_data: got addr=%0h oaddr=%0h data=%0h expected 0", ram_addr, out_addr, out_data);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_aligned();
    int cyc;
    mode = 0;
    do_run(11'd5, 1'b0, 1'b0, cyc);
    checks++;
    if (cyc !== 26) begin errors++; $display("FAIL aligned_done_cycle: got %0d expected 26", cyc); end
    checks++;
    if (busy_cnt !== 25) begin errors++; $display("FAIL aligned_busy_cycles: got %0d expected 25", busy_cnt); end
    checks++;
    if (wren_cnt !== 5) begin errors++; $display("FAIL aligned_writes: got %0d expected 5", wren_cnt); end
    checks++;
    if (rden_cnt !== 15) begin errors++; $display("FAIL aligned_reads: got %0d expected 15", rden_cnt); end
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (wd[n] !== 34'(3 * n) || wa[n] !== 10'(n)) begin
        errors++; $display("FAIL aligned_out[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d", n, wa[n], wd[n], n, 3 * n);
      end
    end
  endtask

  task automatic test_delays();
    int cyc;
    logic [33:0] exp1 [4] = '{34'd1, 34'd2, 34'd3, 34'd3};
    logic [33:0] exp0 [5] = '{34'd0, 34'd1, 34'd3, 34'd6, 34'd9};
    set_dly(2'd0, 6'd0); set_dly(2'd1, 6'd1); set_dly(2'd2, 6'd2);
    mode = 1;
    do_run(11'd4, 1'b0, 1'b0, cyc);
    checks++;
    if (rden_cnt !== 9 || wren_cnt !== 4) begin
      errors++; $display("FAIL delay_reads: got reads=%0d writes=%0d expected reads=9 writes=4", rden_cnt, wren_cnt);
    end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (wd[n] !== exp1[n]) begin errors++; $display("FAIL delay_ones[%0d]: got %0d expected %0d", n, wd[n], exp1[n]); end
    end
    mode = 0;
    do_run(11'd5, 1'b0, 1'b0, cyc);
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (wd[n] !== exp0[n]) begin errors++; $display("FAIL delay_ramp[%0d]: got %0d expected %0d", n, wd[n], exp0[n]); end
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    @(negedge clk);
    num_samples = 11'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (ram_rden !== 1'b1) begin errors++; $display("FAIL midrun_pre_rden: got %b expected 1", ram_rden); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, ram_rden, out_wren, ram_addr, out_addr, out_data} !== '0) begin
      errors++; $display("FAIL midrun_reset_outputs: got busy=%b done=%b rden=%b wren=%b expected all 0", busy, done, ram_rden, out_wren);
    end
    @(negedge clk); rst = 1'b0;
    mode = 0;
    do_run(11'd3, 1'b0, 1'b0, cyc);
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (wd[n] !== 34'(3 * n)) begin errors++; $display("FAIL table_cleared[%0d]: got %0d expected %0d", n, wd[n], 3 * n); end
    end
  endtask

  task automatic test_signmin();
    int cyc;
    mode = 2;
    do_run(11'd1, 1'b0, 1'b0, cyc);
    checks++;
    if (wd.size() !== 1 || wd[0] !== 34'h2_8000_0000) begin
      errors++; $display("FAIL sign_min: got %h expected 280000000", wd[0]);
    end
  endtask

  task automatic test_zero();
    int cyc;
    do_run(11'd0, 1'b0, 1'b0, cyc);
    checks++;
    if (cyc !== 1 || done_cnt !== 1) begin
      errors++; $display("FAIL zero_done: got cycle=%0d pulses=%0d expected cycle=1 pulses=1", cyc, done_cnt);
    end
    checks++;
    if (rden_cnt !== 0 || wren_cnt !== 0 || busy_cnt !== 0) begin
      errors++; $display("FAIL zero_activity: got reads=%0d writes=%0d busy=%0d expected 0", rden_cnt, wren_cnt, busy_cnt);
    end
  endtask

  task automatic test_start_with_write();
    int cyc;
    mode = 1;
    do_run(11'd2, 1'b0, 1'b1, cyc);
    checks++;
    if (rden_cnt !== 5 || wd[0] !== 34'd2 || wd[1] !== 34'd3) begin
      errors++; $display("FAIL start_write: got reads=%0d out0=%0d out1=%0d expected 5 2 3", rden_cnt, wd[0], wd[1]);
    end
    set_dly(2'd0, 6'd0);
  endtask

  task automatic test_ignore_while_busy();
    int cyc;
    mode = 1;
    do_run(11'd3, 1'b1, 1'b0, cyc);
    checks++;
    if (wren_cnt !== 3 || done_cnt !== 1) begin
      errors++; $display("FAIL busy_ignore_count: got writes=%0d done=%0d expected 3 1", wren_cnt, done_cnt);
    end
    do_run(11'd2, 1'b0, 1'b0, cyc);
    checks++;
    if (rden_cnt !== 6 || wd[0] !== 34'd3 || wd[1] !== 34'd3) begin
      errors++; $display("FAIL busy_ignore_table: got reads=%0d out0=%0d out1=%0d expected 6 3 3", rden_cnt, wd[0], wd[1]);
    end
  endtask

  task automatic test_abort();
    mode = 0;
    @(negedge clk);
    clear_mon();
    num_samples = 11'd5; start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 15) begin
        checks++;
        if (out_wren !== 1'b1) begin errors++; $display("FAIL abort_pre_write: got %b expected 1", out_wren); end
        abort = 1'b1;
        #1;
        checks++;
        if (out_wren !== 1'b0) begin errors++; $display("FAIL abort_suppress: got %b expected 0", out_wren); end
      end
      if (i == 16) begin
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          errors++; $display("FAIL abort_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (wren_cnt !== 2 || done_cnt !== 0) begin
      errors++; $display("FAIL abort_totals: got writes=%0d done=%0d expected 2 0", wren_cnt, done_cnt);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    logic [1:0] exp2 [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    mode = 0;
    do_run(11'd6, 1'b0, 1'b0, cyc);
    checks++;
    if (wa2.size() !== 6) begin errors++; $display("FAIL wrap_count: got %0d expected 6", wa2.size()); end
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (wa2[n] !== exp2[n] || wa[n] !== 10'(n)) begin
        errors++; $display("FAIL wrap_addr[%0d]: got %0d/%0d expected %0d/%0d", n, wa2[n], wa[n], exp2[n], n);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    test_reset();
    test_aligned();
    test_delays();
    test_reset_midrun();
    test_signmin();
    test_zero();
    test_start_with_write();
    test_ignore_while_busy();
    test_abort();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
